// File: rtl/bank_mapper_pkg.sv
// Shared constants and window configuration layout for the $8000-$FFFF bank mapper.
package bank_mapper_pkg;

    localparam int CPU_ADDR_WIDTH = 16;
    localparam int DATA_WIDTH     = 8;
    localparam int MAX_BANK_BITS  = 5;

    localparam int BANK_CTL_ENABLE = 7;
    localparam int BANK_CTL_WP     = 6;
    localparam int BANK_CTL_PEEK   = 5;

    localparam int BANK_CMD_COMMIT = 0;
    localparam int BANK_CMD_CLEAR  = 1;

    localparam logic [3:0] CMD_OFFSET = 4'hF;

    // Field order matches the register byte, so a cfg reads back as-is.
    typedef struct packed {
        logic                     enable;
        logic                     wp;
        logic                     peek;
        logic [MAX_BANK_BITS-1:0] bank;
    } window_cfg_t;

    function automatic window_cfg_t cfg_from_byte(input logic [DATA_WIDTH-1:0] d,
                                                  input int bank_bits);
        window_cfg_t c;
        c.enable = d[BANK_CTL_ENABLE];
        c.wp     = d[BANK_CTL_WP];
        c.peek   = d[BANK_CTL_PEEK];
        for (int i = 0; i < MAX_BANK_BITS; i++) begin
            c.bank[i] = (i < bank_bits) ? d[i] : 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/bank_mapper_window_regs.sv
// Double-buffered window registers: shadow written by the CPU, active loaded on commit.
module bank_window_regs
    import bank_mapper_pkg::*;
#(
    parameter int NUM_WINDOWS = 4,
    parameter int BANK_BITS   = 3
) (
    input  logic                                  sys_clock_i,
    input  logic                                  reset_i,
    input  logic                                  ctl_hit,
    input  logic                                  ctl_wr,
    input  logic [3:0]                            ctl_offset,
    input  logic [DATA_WIDTH-1:0]                 ctl_wdata,
    input  logic                                  violation,
    output logic                                  pending,
    output logic [NUM_WINDOWS*$bits(window_cfg_t)-1:0] active,
    output logic [DATA_WIDTH-1:0]                 rd_data
);

    localparam int IDX_W = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;

    window_cfg_t [NUM_WINDOWS-1:0] shadow;
    window_cfg_t [NUM_WINDOWS-1:0] act;
    logic [DATA_WIDTH-1:0]         rd_next;
    logic                          win_sel;

    assign win_sel = int'(ctl_offset) < NUM_WINDOWS;
    assign active  = act;

    always_comb begin
        rd_next = '0;
        if (ctl_hit) begin
            if (ctl_offset == CMD_OFFSET) begin
                rd_next = {violation, 6'b0, pending};
            end else if (win_sel) begin
                rd_next = shadow[ctl_offset[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            shadow  <= '0;
            act     <= '0;
            pending <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
            if (ctl_wr) begin
                if (win_sel) begin
                    shadow[ctl_offset[IDX_W-1:0]] <= cfg_from_byte(ctl_wdata, BANK_BITS);
                    pending                       <= 1'b1;
                end else if (ctl_offset == CMD_OFFSET && ctl_wdata[BANK_CMD_COMMIT]) begin
                    act     <= shadow;
                    pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bank_mapper.sv
// Maps $8000-$FFFF onto NUM_WINDOWS bankable windows; registered decode and write-protect trap.
module bank_mapper
    import bank_mapper_pkg::*;
#(
    parameter int          NUM_WINDOWS = 4,
    parameter int          BANK_BITS   = 3,
    parameter logic [15:0] CTL_BASE    = 16'hFFF0
) (
    input  logic                      sys_clock_i,
    input  logic                      reset_i,
    input  logic                      cpu_be_i,
    input  logic                      cpu_wr_strobe_i,
    input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]     cpu_data_i,
    output logic [DATA_WIDTH-1:0]     ctl_rd_data_o,
    output logic                      ctl_hit_o,
    output logic                      bank_en_o,
    output logic [BANK_BITS-1:0]      bank_addr_o,
    output logic                      bank_ro_o,
    output logic                      wr_blocked_o,
    output logic                      violation_o
);

    localparam int WIN_BITS = $clog2(NUM_WINDOWS);
    localparam int IDX_W    = (WIN_BITS > 0) ? WIN_BITS : 1;

    if (NUM_WINDOWS < 1 || NUM_WINDOWS > 8 || (NUM_WINDOWS & (NUM_WINDOWS - 1)) != 0) begin : g_chk_windows
        $error("bank_mapper: NUM_WINDOWS must be a power of two in 1..8");
    end
    if (BANK_BITS < 1 || BANK_BITS > MAX_BANK_BITS) begin : g_chk_bank_bits
        $error("bank_mapper: BANK_BITS must be in 1..5");
    end
    if (CTL_BASE[3:0] != 4'h0) begin : g_chk_ctl_base
        $error("bank_mapper: CTL_BASE must be 16-aligned");
    end

    window_cfg_t [NUM_WINDOWS-1:0] act;
    window_cfg_t                   cur;
    logic [IDX_W-1:0]              win_idx;
    logic                          ctl_sel;
    logic                          ctl_wr;
    logic                          peek_hole;
    logic                          redirect;
    logic                          trap;
    logic                          clear_req;
    logic                          pending;
    logic                          unused_cfg;

    bank_window_regs #(
        .NUM_WINDOWS (NUM_WINDOWS),
        .BANK_BITS   (BANK_BITS)
    ) u_regs (
        .sys_clock_i (sys_clock_i),
        .reset_i     (reset_i),
        .ctl_hit     (ctl_sel),
        .ctl_wr      (ctl_wr),
        .ctl_offset  (cpu_addr_i[3:0]),
        .ctl_wdata   (cpu_data_i),
        .violation   (violation_o),
        .pending     (pending),
        .active      (act),
        .rd_data     (ctl_rd_data_o)
    );

    // Top address bits below A15 select the window; a single window gets index 0.
    assign win_idx   = IDX_W'(cpu_addr_i[14:0] >> (15 - WIN_BITS));
    assign cur       = act[win_idx];
    assign ctl_sel   = cpu_addr_i[15:4] == CTL_BASE[15:4];
    assign ctl_wr    = cpu_wr_strobe_i && cpu_be_i && ctl_sel;
    assign peek_hole = cur.peek && (cpu_addr_i[15:12] == 4'h8 || cpu_addr_i[15:11] == 5'b11101);
    assign redirect  = cpu_be_i && cpu_addr_i[15] && cur.enable && !peek_hole && !ctl_sel;
    assign trap      = cpu_wr_strobe_i && redirect && cur.wp;
    assign clear_req = ctl_wr && cpu_addr_i[3:0] == CMD_OFFSET && cpu_data_i[BANK_CMD_CLEAR];
    assign unused_cfg = ^{cur.bank, pending};

    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            ctl_hit_o    <= 1'b0;
            bank_en_o    <= 1'b0;
            bank_addr_o  <= '0;
            bank_ro_o    <= 1'b0;
            wr_blocked_o <= 1'b0;
            violation_o  <= 1'b0;
        end else begin
            ctl_hit_o    <= ctl_sel;
            bank_en_o    <= redirect;
            bank_addr_o  <= redirect ? cur.bank[BANK_BITS-1:0] : '0;
            bank_ro_o    <= redirect && cur.wp;
            wr_blocked_o <= trap;
            // A trap on the same edge as a clear keeps the flag set.
            if (trap) begin
                violation_o <= 1'b1;
            end else if (clear_req) begin
                violation_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bank_mapper.sv
// Self-checking bench for bank_mapper: directed scenarios plus randomized traffic against a model.
module tb_bank_mapper;

    localparam int NW = 4;
    localparam int BB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          be  = 1'b0;
    logic          wr  = 1'b0;
    logic [15:0]   addr = 16'h0;
    logic [7:0]    data = 8'h0;
    logic [7:0]    rd_data;
    logic          ctl_hit;
    logic          bank_en;
    logic [BB-1:0] bank_addr;
    logic          bank_ro;
    logic          wr_blocked;
    logic          violation;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bank_mapper #(
        .NUM_WINDOWS (NW),
        .BANK_BITS   (BB),
        .CTL_BASE    (16'hFFF0)
    ) dut (
        .sys_clock_i     (clk),
        .reset_i         (rst),
        .cpu_be_i        (be),
        .cpu_wr_strobe_i (wr),
        .cpu_addr_i      (addr),
        .cpu_data_i      (data),
        .ctl_rd_data_o   (rd_data),
        .ctl_hit_o       (ctl_hit),
        .bank_en_o       (bank_en),
        .bank_addr_o     (bank_addr),
        .bank_ro_o       (bank_ro),
        .wr_blocked_o    (wr_blocked),
        .violation_o     (violation)
    );

    // Reference model: per-window fields as plain arrays, windows found by division.
    bit m_sh_en [NW];
    bit m_sh_wp [NW];
    bit m_sh_pk [NW];
    int m_sh_bank [NW];
    bit m_ac_en [NW];
    bit m_ac_wp [NW];
    bit m_ac_pk [NW];
    int m_ac_bank [NW];
    bit m_pending;
    bit m_viol;

    int e_rd;
    bit e_hit, e_en, e_ro, e_blk, e_viol;
    int e_bank;

    function automatic void model_reset();
        for (int i = 0; i < NW; i++) begin
            m_sh_en[i] = 0; m_sh_wp[i] = 0; m_sh_pk[i] = 0; m_sh_bank[i] = 0;
            m_ac_en[i] = 0; m_ac_wp[i] = 0; m_ac_pk[i] = 0; m_ac_bank[i] = 0;
        end
        m_pending = 0;
        m_viol    = 0;
    endfunction

    function automatic void model_cycle(input bit b, input bit w, input int a, input int d);
        int  win, off;
        bit  ctl, hole, en, clr;
        ctl  = (a >= 'hFFF0);
        off  = a - 'hFFF0;
        hole = (a >= 'h8000 && a < 'h9000) || (a >= 'hE800 && a < 'hF000);
        en   = 0;
        win  = 0;
        if (b && a >= 'h8000) begin
            win = (a - 'h8000) / ('h8000 / NW);
            en  = m_ac_en[win] && !(m_ac_pk[win] && hole) && !ctl;
        end
        e_hit  = ctl;
        e_en   = en;
        e_bank = en ? m_ac_bank[win] : 0;
        e_ro   = en && m_ac_wp[win];
        e_blk  = w && b && en && m_ac_wp[win];
        e_rd   = 0;
        if (ctl) begin
            if (off == 15) e_rd = 128 * int'(m_viol) + int'(m_pending);
            else if (off < NW) e_rd = 128 * int'(m_sh_en[off]) + 64 * int'(m_sh_wp[off])
                                    + 32 * int'(m_sh_pk[off]) + m_sh_bank[off];
        end
        clr = 0;
        if (w && b && ctl) begin
            if (off < NW) begin
                m_sh_en[off]   = d[7];
                m_sh_wp[off]   = d[6];
                m_sh_pk[off]   = d[5];
                m_sh_bank[off] = d % (1 << BB);
                m_pending      = 1;
            end else if (off == 15) begin
                if (d % 2 == 1) begin
                    for (int i = 0; i < NW; i++) begin
                        m_ac_en[i] = m_sh_en[i]; m_ac_wp[i] = m_sh_wp[i];
                        m_ac_pk[i] = m_sh_pk[i]; m_ac_bank[i] = m_sh_bank[i];
                    end
                    m_pending = 0;
                end
                clr = (d / 2) % 2 == 1;
            end
        end
        if (e_blk) m_viol = 1;
        else if (clr) m_viol = 0;
        e_viol = m_viol;
    endfunction

    task automatic step(input bit b, input bit w, input logic [15:0] a, input logic [7:0] d);
        be   = b;
        wr   = w;
        addr = a;
        data = d;
        model_cycle(b, w, int'(a), int'(d));
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        be  = 1'b0;
        wr  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        step(1, 0, 16'hA000, 8'h00);
        checks++; if (bank_en !== 1'b0) begin errors++; $display("FAIL reset_bank_en got %0b want 0", bank_en); end
        checks++; if (ctl_hit !== 1'b0) begin errors++; $display("FAIL reset_ctl_hit got %0b want 0", ctl_hit); end
        checks++; if (violation !== 1'b0) begin errors++; $display("FAIL reset_violation got %0b want 0", violation); end
    endtask

    task automatic test_commit();
        step(1, 1, 16'hFFF1, 8'h83);
        step(1, 0, 16'hA000, 8'h00);
        checks++; if (bank_en !== 1'b0) begin errors++; $display("FAIL uncommitted_en got %0b want 0", bank_en); end
        step(1, 0, 16'hFFFF, 8'h00);
        checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL pending_status got %h want 01", rd_data); end
        step(1, 1, 16'hFFFF, 8'h01);
        step(1, 0, 16'hA000, 8'h00);
        checks++; if ({bank_en, bank_addr, bank_ro} !== {1'b1, 3'd3, 1'b0})
            begin errors++; $display("FAIL committed_decode got en=%0b bank=%0d ro=%0b want en=1 bank=3 ro=0", bank_en, bank_addr, bank_ro); end
        step(1, 0, 16'hFFFF, 8'h00);
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL status_after_commit got %h want 00", rd_data); end
        step(1, 0, 16'hFFF1, 8'h00);
        checks++; if (rd_data !== 8'h83) begin errors++; $display("FAIL shadow_readback got %h want 83", rd_data); end
        step(1, 1, 16'hFFF6, 8'hFF);
        step(1, 0, 16'hFFF6, 8'h00);
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL unused_reg_read got %h want 00", rd_data); end
        step(1, 0, 16'hFFFF, 8'h00);
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL unused_write_pending got %h want 00", rd_data); end
        step(1, 1, 16'hFFF0, 8'h1F);
        step(1, 0, 16'hFFF0, 8'h00);
        checks++; if (rd_data !== 8'h07) begin errors++; $display("FAIL bank_mask_readback got %h want 07", rd_data); end
    endtask

    task automatic test_trap();
        step(1, 1, 16'hFFF3, 8'hC2);
        step(1, 1, 16'hFFFF, 8'h01);
        step(1, 1, 16'hC123, 8'h55);
        checks++; if ({wr_blocked, violation} !== 2'b00)
            begin errors++; $display("FAIL disabled_window_no_trap got blk=%0b viol=%0b want 0 0", wr_blocked, violation); end
        step(1, 1, 16'hE123, 8'h55);
        checks++; if ({wr_blocked, bank_ro, bank_en, bank_addr, violation} !== {1'b1, 1'b1, 1'b1, 3'd2, 1'b1})
            begin errors++; $display("FAIL trap got blk=%0b ro=%0b en=%0b bank=%0d viol=%0b want 1 1 1 2 1", wr_blocked, bank_ro, bank_en, bank_addr, violation); end
        step(1, 0, 16'hA000, 8'h00);
        checks++; if ({wr_blocked, violation} !== 2'b01)
            begin errors++; $display("FAIL sticky got blk=%0b viol=%0b want 0 1", wr_blocked, violation); end
        step(1, 0, 16'hFFFF, 8'h00);
        checks++; if (rd_data !== 8'h80) begin errors++; $display("FAIL status_violation got %h want 80", rd_data); end
        step(1, 1, 16'hFFFF, 8'h02);
        checks++; if (violation !== 1'b0) begin errors++; $display("FAIL clear got %0b want 0", violation); end
        step(1, 1, 16'hE123, 8'hAA);
        checks++; if (violation !== 1'b1) begin errors++; $display("FAIL trap_after_clear got %0b want 1", violation); end
        step(1, 1, 16'hFFFF, 8'h03);
        checks++; if (violation !== 1'b0) begin errors++; $display("FAIL commit_and_clear got %0b want 0", violation); end
    endtask

    task automatic test_peek();
        logic [15:0] pa [10];
        logic        pe [10];
        pa = '{16'h8400, 16'h8FFF, 16'h9000, 16'hE000, 16'hE7FF, 16'hE800, 16'hE900, 16'hEFFF, 16'hF000, 16'hFFF5};
        pe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        step(1, 1, 16'hFFF0, 8'hA1);
        step(1, 1, 16'hFFF3, 8'hA1);
        step(1, 1, 16'hFFFF, 8'h01);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, pa[i], 8'h00);
            checks++; if (bank_en !== pe[i])
                begin errors++; $display("FAIL peek_en addr=%h got %0b want %0b", pa[i], bank_en, pe[i]); end
        end
        checks++; if (ctl_hit !== 1'b1) begin errors++; $display("FAIL ctl_hit_fff5 got %0b want 1", ctl_hit); end
        step(1, 1, 16'hFFF0, 8'h00);
        step(1, 0, 16'h9000, 8'h00);
        checks++; if (bank_en !== 1'b1) begin errors++; $display("FAIL old_active_kept got %0b want 1", bank_en); end
        step(1, 1, 16'hFFFF, 8'h01);
        step(1, 0, 16'h9000, 8'h00);
        checks++; if (bank_en !== 1'b0) begin errors++; $display("FAIL disable_committed got %0b want 0", bank_en); end
    endtask

    task automatic test_be_idle();
        step(1, 1, 16'hFFF3, 8'hC2);
        step(1, 1, 16'hFFFF, 8'h01);
        step(1, 0, 16'hA000, 8'h00);
        checks++; if ({bank_en, bank_addr} !== {1'b1, 3'd3})
            begin errors++; $display("FAIL be_on_decode got en=%0b bank=%0d want 1 3", bank_en, bank_addr); end
        step(0, 0, 16'hA000, 8'h00);
        checks++; if ({bank_en, bank_addr, bank_ro, wr_blocked} !== 6'b0)
            begin errors++; $display("FAIL be_off_idle got en=%0b bank=%0d ro=%0b blk=%0b want 0", bank_en, bank_addr, bank_ro, wr_blocked); end
        step(0, 1, 16'hE123, 8'h11);
        checks++; if ({bank_en, bank_ro, wr_blocked, violation} !== 4'b0)
            begin errors++; $display("FAIL be_off_no_trap got en=%0b ro=%0b blk=%0b viol=%0b want 0", bank_en, bank_ro, wr_blocked, violation); end
    endtask

    task automatic test_reset_during_commit();
        step(1, 1, 16'hFFF2, 8'h85);
        rst  = 1'b1;
        be   = 1'b1;
        wr   = 1'b1;
        addr = 16'hFFFF;
        data = 8'h01;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr  = 1'b0;
        model_reset();
        checks++; if ({rd_data, ctl_hit, bank_en, bank_addr, bank_ro, wr_blocked, violation} !== 16'h0)
            begin errors++; $display("FAIL reset_outputs got rd=%h hit=%0b en=%0b viol=%0b want 0", rd_data, ctl_hit, bank_en, violation); end
        step(1, 0, 16'hFFF2, 8'h00);
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_shadow got %h want 00", rd_data); end
        step(1, 0, 16'hFFFF, 8'h00);
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", rd_data); end
        step(1, 0, 16'hA000, 8'h00);
        checks++; if (bank_en !== 1'b0) begin errors++; $display("FAIL reset_active got %0b want 0", bank_en); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [15:0] a;
        logic [15:0] obs, expv;
        bit          b, w;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom();
            b = (r[2:0] != 3'd0);
            w = b && (r[4:3] != 2'd0);
            if (r[6:5] == 2'd0) a = {12'hFFF, r[10:7]};
            else a = r[31:16];
            r = $urandom();
            step(b, w, a, r[7:0]);
            obs  = {rd_data, ctl_hit, bank_en, bank_addr, bank_ro, wr_blocked, violation};
            expv = {8'(e_rd), e_hit, e_en, BB'(e_bank), e_ro, e_blk, e_viol};
            checks++; if (obs !== expv)
                begin errors++; $display("FAIL random n=%0d addr=%h got %h want %h", n, a, obs, expv); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_commit();
        test_trap();
        test_peek();
        test_be_idle();
        test_reset_during_commit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
